am2910_ustore: RTL and testbench
================================

# am2910_ustore

Writable microprogram store and pipeline register that sits directly downstream of the am2910 sequencer and closes its loop. Each clock it fetches the microword addressed by the sequencer's Y output into a pipeline register. That register drives the sequencer's I, CCEN_BAR, RLD_BAR, CI and D inputs. It also drives CC_BAR through a polarity-selectable condition multiplexer. A small run-control FSM covers microcode loading, run, halt, single-step and address-fault handling.

## Interface
- ADDR_BITS, 6, store depth is 2**ADDR_BITS words; valid Y range 0..2**ADDR_BITS-1
- clk  in  1  single clock, all state updates on posedge
- RST_BAR  in  1  asynchronous, active-low reset
- Y  in  12  microaddress from sequencer
- STATUS  in  8  datapath status flags, sampled every posedge into status_q
- WE_VALID  in  1  microcode write request
- WE_READY  out  1  store accepts a write this cycle
- WE_ADDR  in  ADDR_BITS  write address
- WE_DATA  in  24  microword to write
- START  in  1  leave LOAD and begin execution at address 0
- STEP  in  1  execute one microword while halted
- RESUME  in  1  continue execution from halt
- I  out  4  pipeline field [3:0]
- CCEN_BAR  out  1  pipeline field [4]
- RLD_BAR  out  1  pipeline field [5]
- CI  out  1  pipeline field [6]
- D  out  12  pipeline field [22:11]
- CC_BAR  out  1  ~(status_q[CSEL] ^ CPOL), combinational from registers
- RUNNING  out  1  state is RUN or STEP
- HALTED  out  1  state is HALT
- FAULT  out  1  sticky out-of-range fetch flag

## Operation
- Microword layout:
  - [3:0] I
  - [4] CCEN_BAR
  - [5] RLD_BAR
  - [6] CI
  - [9:7] CSEL
  - [10] CPOL
  - [22:11] D
  - [23] HALT
- Store: 2**ADDR_BITS x 24.
  - Asynchronous read.
  - Synchronous write.
  - Initial contents zero.
  - Not cleared by reset.
- CLEAR word: I=0, CCEN_BAR=1, RLD_BAR=1, CI=0, other fields 0. Under it the sequencer outputs Y=0.
- HOLD word: I=14 (CONT), CCEN_BAR=1, RLD_BAR=1, CI=0, other fields 0. Under it Y=uPC and uPC does not advance.
- A fetch means: pipeline <= store[Y[ADDR_BITS-1:0]].
- A fetch faults if Y[11:ADDR_BITS] != 0. A faulting fetch loads the HOLD word instead, sets state to HALT and sets FAULT (held until reset).
- States and transitions:
  - LOAD:
    - Pipeline = CLEAR word.
    - WE_READY = ~START.
    - A write occurs on a posedge with WE_VALID & WE_READY.
    - START -> RUN with a fetch (Y=0).
    - STEP and RESUME are ignored.
  - RUN:
    - If the current pipeline HALT bit = 1: -> HALT, pipeline <= HOLD. The halt word itself is presented to the sequencer for exactly one cycle.
    - Otherwise: fetch every cycle.
  - HALT:
    - Pipeline holds the HOLD word.
    - RESUME -> RUN with a fetch.
    - STEP (without RESUME) -> STEP with a fetch.
    - RESUME wins if asserted together with STEP.
  - STEP: -> HALT, pipeline <= HOLD, regardless of the HALT bit.
- START is ignored outside LOAD. Only reset returns the block to LOAD.
- WE_READY = 0 in all states other than LOAD.

## Timing
- Reset values (applied asynchronously):
  - state LOAD, pipeline = CLEAR word, status_q = 0
  - I=0, CCEN_BAR=1, RLD_BAR=1, CI=0, D=0, CC_BAR=1
  - RUNNING=0, HALTED=0, FAULT=0, WE_READY=1 (while START=0)
- Fetch latency: Y sampled at edge n appears on I/D/... after edge n. This is one cycle and matches the sequencer's loop.
- CC_BAR reflects the STATUS value sampled at the previous edge, with CSEL/CPOL from the current pipeline word.
- Halt: a HALT word at address a executes in cycle k. HALTED rises after edge k+1. If the word had CI=1, Y then holds a+1.
- STEP: the fetched word is presented for exactly one cycle, then HALTED=1 again.
- Fault and HALT bit in the same RUN cycle: the HALT-bit transition takes precedence and no fetch is performed, so no fault is recorded.
- Reset mid-operation: outputs go to reset values immediately and the store is retained. START then re-runs from address 0.

## Test plan
- Reset, then write words 0..3 with WE_VALID held high -> four writes accepted on consecutive edges; WE_READY=0 in the cycle START=1 and in every cycle after.
- Words 0..2 = CONT with CI=1, word 3 = CONT, CI=1, HALT=1; pulse START -> I=14 driven for 4 cycles, HALTED=1 on the 5th post-START cycle, Y held at 4.
- While halted, word 4 = CONT, CI=1, HALT=0; pulse STEP once -> word 4 presented one cycle, HALTED=1 again, Y holds 5; RUNNING high only during the step cycle.
- Word with CSEL=5, CPOL=0 and STATUS=8'h20 -> CC_BAR=0; same word with CPOL=1 -> CC_BAR=1; STATUS change affects CC_BAR one edge later.
- ADDR_BITS=6, word = JMAP/JZ-style jump with I=2, D=12'h040 -> next fetch faults: FAULT=1, HALTED=1, pipeline = HOLD word; RESUME re-faults while Y stays at 12'h040.
- Assert RST_BAR=0 mid-RUN -> all outputs at reset values before the next edge; after release, START re-executes the stored program from address 0 with unchanged contents.

Source files
------------

// File: rtl/am2910_ustore_if.sv
// Microcode write port of the am2910 microprogram store.
// The loader is the master, the store is the slave.
interface am2910_ustore_if #(
  parameter int ADDR_BITS = 6
);
  logic                 WE_VALID;
  logic                 WE_READY;
  logic [ADDR_BITS-1:0] WE_ADDR;
  logic [23:0]          WE_DATA;

  modport master (
    output WE_VALID,
    output WE_ADDR,
    output WE_DATA,
    input  WE_READY
  );

  modport slave (
    input  WE_VALID,
    input  WE_ADDR,
    input  WE_DATA,
    output WE_READY
  );
endinterface

// File: rtl/am2910_ustore.sv
// Writable microprogram store, pipeline register and run control
// closing the loop around an am2910 sequencer.
module am2910_ustore #(
  parameter int ADDR_BITS = 6
) (
  input  logic           clk,
  input  logic           RST_BAR,
  input  logic [11:0]    Y,
  input  logic [7:0]     STATUS,
  am2910_ustore_if.slave we,
  input  logic           START,
  input  logic           STEP,
  input  logic           RESUME,
  output logic [3:0]     I,
  output logic           CCEN_BAR,
  output logic           RLD_BAR,
  output logic           CI,
  output logic [11:0]    D,
  output logic           CC_BAR,
  output logic           RUNNING,
  output logic           HALTED,
  output logic           FAULT
);

  typedef struct packed {
    logic        halt;
    logic [11:0] d;
    logic        cpol;
    logic [2:0]  csel;
    logic        ci;
    logic        rld_bar;
    logic        ccen_bar;
    logic [3:0]  i;
  } uword_t;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT,
    S_STEP
  } state_e;

  // CLEAR forces Y=0 (JZ); HOLD parks Y on uPC (CONT, CI=0)
  localparam uword_t CLEAR_W = 24'h000030;
  localparam uword_t HOLD_W  = 24'h00003E;

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [23:0] mem [0:DEPTH-1];

  state_e state_q, state_d;
  uword_t pipe_q, pipe_d;
  logic   fault_q, fault_d;
  logic [7:0] status_q, status_d;

  logic   fetch;
  state_e fetch_to;
  logic   fetch_bad;
  uword_t rd_word;
  logic   we_ready;
  logic   we_fire;

  assign rd_word   = uword_t'(mem[Y[ADDR_BITS-1:0]]);
  assign fetch_bad = |(Y >> ADDR_BITS);
  assign we_ready  = (state_q == S_LOAD) & ~START;
  assign we_fire   = we.WE_VALID & we_ready;

  assign we.WE_READY = we_ready;

  always_ff @(posedge clk) begin
    if (we_fire) begin
      mem[we.WE_ADDR] <= we.WE_DATA;
    end
  end

  always_comb begin
    state_d  = state_q;
    pipe_d   = pipe_q;
    fault_d  = fault_q;
    status_d = STATUS;
    fetch    = 1'b0;
    fetch_to = S_RUN;
    unique case (state_q)
      S_LOAD: begin
        if (START) begin
          fetch = 1'b1;
        end else begin
          pipe_d = CLEAR_W;
        end
      end
      S_RUN: begin
        // halt bit wins over any fetch, so no fault can be raised here
        if (pipe_q.halt) begin
          state_d = S_HALT;
          pipe_d  = HOLD_W;
        end else begin
          fetch = 1'b1;
        end
      end
      S_HALT: begin
        pipe_d = HOLD_W;
        if (RESUME) begin
          fetch = 1'b1;
        end else if (STEP) begin
          fetch    = 1'b1;
          fetch_to = S_STEP;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
        pipe_d  = HOLD_W;
      end
      default: begin
        state_d = S_LOAD;
        pipe_d  = CLEAR_W;
      end
    endcase
    if (fetch) begin
      if (fetch_bad) begin
        pipe_d  = HOLD_W;
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        pipe_d  = rd_word;
        state_d = fetch_to;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q  <= S_LOAD;
      pipe_q   <= CLEAR_W;
      fault_q  <= 1'b0;
      status_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      pipe_q   <= pipe_d;
      fault_q  <= fault_d;
      status_q <= status_d;
    end
  end

  assign I        = pipe_q.i;
  assign CCEN_BAR = pipe_q.ccen_bar;
  assign RLD_BAR  = pipe_q.rld_bar;
  assign CI       = pipe_q.ci;
  assign D        = pipe_q.d;
  assign CC_BAR   = ~(status_q[pipe_q.csel] ^ pipe_q.cpol);
  assign RUNNING  = (state_q == S_RUN) | (state_q == S_STEP);
  assign HALTED   = (state_q == S_HALT);
  assign FAULT    = fault_q;

endmodule

// File: tb/tb_am2910_ustore.sv
// Bench for am2910_ustore: directed sequencer-in-the-loop steps
// followed by random stimulus, all against a behavioural model.
module tb_am2910_ustore;

  localparam int AB = 6;

  logic        clk = 1'b0;
  logic        RST_BAR = 1'b1;
  logic [11:0] Y = 12'h000;
  logic [7:0]  STATUS = 8'h00;
  logic        START = 1'b0;
  logic        STEP = 1'b0;
  logic        RESUME = 1'b0;
  logic [3:0]  I;
  logic        CCEN_BAR;
  logic        RLD_BAR;
  logic        CI;
  logic [11:0] D;
  logic        CC_BAR;
  logic        RUNNING;
  logic        HALTED;
  logic        FAULT;

  am2910_ustore_if #(.ADDR_BITS(AB)) wif ();

  am2910_ustore #(.ADDR_BITS(AB)) dut (
    .clk      (clk),
    .RST_BAR  (RST_BAR),
    .Y        (Y),
    .STATUS   (STATUS),
    .we       (wif),
    .START    (START),
    .STEP     (STEP),
    .RESUME   (RESUME),
    .I        (I),
    .CCEN_BAR (CCEN_BAR),
    .RLD_BAR  (RLD_BAR),
    .CI       (CI),
    .D        (D),
    .CC_BAR   (CC_BAR),
    .RUNNING  (RUNNING),
    .HALTED   (HALTED),
    .FAULT    (FAULT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum {M_LOAD, M_RUN, M_HALT, M_STEP} mmode_e;

  localparam logic [23:0] W_CLEAR = 24'h000030;
  localparam logic [23:0] W_HOLD  = 24'h00003E;

  logic [23:0] m_mem [64];
  logic [23:0] m_pipe = W_CLEAR;
  logic [7:0]  m_stat = 8'h00;
  logic        m_fault = 1'b0;
  mmode_e      m_mode = M_LOAD;
  logic [11:0] upc = 12'h000;

  function automatic logic [23:0] mk(int op, bit ccen, bit rld, bit ci,
                                     int csel, bit cpol, int d, bit halt);
    return {halt, d[11:0], cpol, csel[2:0], ci, rld, ccen, op[3:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ccbar();
    return ~(m_stat[m_pipe[9:7]] ^ m_pipe[10]);
  endfunction

  task automatic check_all();
    chk("I", 32'(I), 32'(m_pipe[3:0]));
    chk("ctl", 32'({CCEN_BAR, RLD_BAR, CI}),
        32'({m_pipe[4], m_pipe[5], m_pipe[6]}));
    chk("D", 32'(D), 32'(m_pipe[22:11]));
    chk("CC_BAR", 32'(CC_BAR), 32'(m_ccbar()));
    chk("RUNNING", 32'(RUNNING), 32'(m_mode inside {M_RUN, M_STEP}));
    chk("HALTED", 32'(HALTED), 32'(m_mode == M_HALT));
    chk("FAULT", 32'(FAULT), 32'(m_fault));
    chk("WE_READY", 32'(wif.WE_READY),
        32'(m_mode == M_LOAD && !START));
  endtask

  task automatic m_fetch(mmode_e nxt);
    if (Y[11:6] != 6'd0) begin
      m_pipe  = W_HOLD;
      m_mode  = M_HALT;
      m_fault = 1'b1;
    end else begin
      m_pipe = m_mem[Y[5:0]];
      m_mode = nxt;
    end
  endtask

  // One posedge of the specified behaviour plus the sequencer's uPC
  task automatic model_edge();
    logic [23:0] cur;
    cur = m_pipe;
    upc = Y + 12'(cur[6]);
    if (m_mode == M_LOAD && wif.WE_VALID && !START)
      m_mem[wif.WE_ADDR] = wif.WE_DATA;
    case (m_mode)
      M_LOAD: if (START) m_fetch(M_RUN); else m_pipe = W_CLEAR;
      M_RUN: begin
        if (cur[23]) begin
          m_mode = M_HALT;
          m_pipe = W_HOLD;
        end else begin
          m_fetch(M_RUN);
        end
      end
      M_HALT: begin
        if (RESUME) m_fetch(M_RUN);
        else if (STEP) m_fetch(M_STEP);
      end
      default: begin
        m_mode = M_HALT;
        m_pipe = W_HOLD;
      end
    endcase
    m_stat = STATUS;
  endtask

  // Minimal am2910 next-address for the opcodes the bench uses
  function automatic logic [11:0] seq_y();
    bit pass;
    pass = m_pipe[4] | ~m_ccbar();
    case (m_pipe[3:0])
      4'd0: return 12'h000;
      4'd2: return m_pipe[22:11];
      4'd3: return pass ? m_pipe[22:11] : upc;
      default: return upc;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic seq_tick();
    Y = seq_y();
    tick();
  endtask

  task automatic wr(int a, logic [23:0] d);
    wif.WE_VALID = 1'b1;
    wif.WE_ADDR  = 6'(a);
    wif.WE_DATA  = d;
    seq_tick();
  endtask

  task automatic do_reset();
    START = 1'b0;
    STEP = 1'b0;
    RESUME = 1'b0;
    wif.WE_VALID = 1'b0;
    RST_BAR = 1'b0;
    #1;
    m_mode = M_LOAD;
    m_pipe = W_CLEAR;
    m_stat = 8'h00;
    m_fault = 1'b0;
    upc = 12'h000;
    chk("rst_out", 32'({I, CCEN_BAR, RLD_BAR, CI, D, CC_BAR,
                        RUNNING, HALTED, FAULT, wif.WE_READY}),
        32'h0C0011);
    check_all();
    #1 RST_BAR = 1'b1;
  endtask

  task automatic start_pulse();
    wif.WE_VALID = 1'b0;
    START = 1'b1;
    seq_tick();
    START = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [23:0] cont_ci;
    logic [23:0] w;
    cont_ci = mk(14, 1, 1, 1, 0, 0, 0, 0);
    wif.WE_VALID = 1'b0;
    wif.WE_ADDR = '0;
    wif.WE_DATA = '0;
    for (int k = 0; k < 64; k++) m_mem[k] = 24'h0;
    #2;
    do_reset();

    // fill every word so nothing depends on power-up contents
    for (int k = 0; k < 64; k++) wr(k, mk(14, 1, 1, 0, 0, 0, 0, 1));
    wr(0, cont_ci);
    wr(1, cont_ci);
    wr(2, cont_ci);
    wr(3, mk(14, 1, 1, 1, 0, 0, 0, 1));
    wr(4, cont_ci);
    wr(5, cont_ci);
    wr(6, mk(2, 1, 1, 0, 0, 0, 6, 0));

    // write offered with START must be refused
    wif.WE_VALID = 1'b1;
    wif.WE_ADDR = 6'd0;
    wif.WE_DATA = 24'hFFFFFF;
    START = 1'b1;
    #1 chk("we_ready_start", 32'(wif.WE_READY), 32'd0);
    seq_tick();
    START = 1'b0;
    wif.WE_VALID = 1'b0;
    repeat (8) seq_tick();
    chk("run_halted", 32'(HALTED), 32'd1);
    chk("hold_I", 32'(I), 32'd14);

    STEP = 1'b1;
    seq_tick();
    STEP = 1'b0;
    chk("step_running", 32'(RUNNING), 32'd1);
    seq_tick();
    chk("step_rehalt", 32'(HALTED), 32'd1);

    RESUME = 1'b1;
    seq_tick();
    RESUME = 1'b0;
    repeat (5) seq_tick();
    chk("loop_running", 32'(RUNNING), 32'd1);

    // reset mid-run, then rerun the retained program
    do_reset();
    start_pulse();
    repeat (8) seq_tick();
    chk("rerun_halted", 32'(HALTED), 32'd1);

    // condition mux polarity and one-edge status latency
    do_reset();
    wr(0, mk(2, 1, 1, 0, 0, 0, 8, 0));
    wr(8, mk(14, 1, 1, 0, 5, 0, 0, 0));
    start_pulse();
    seq_tick();
    seq_tick();
    STATUS = 8'h20;
    seq_tick();
    chk("cc_pol0", 32'(CC_BAR), 32'd0);
    STATUS = 8'h00;
    #1 chk("cc_latency", 32'(CC_BAR), 32'd0);
    seq_tick();
    chk("cc_pol0_clr", 32'(CC_BAR), 32'd1);

    do_reset();
    wr(8, mk(14, 1, 1, 0, 5, 1, 0, 0));
    start_pulse();
    seq_tick();
    STATUS = 8'h20;
    seq_tick();
    chk("cc_pol1", 32'(CC_BAR), 32'd1);
    STATUS = 8'h00;

    // out-of-range jump faults, resume faults again
    do_reset();
    wr(0, mk(2, 1, 1, 0, 0, 0, 12'h040, 0));
    start_pulse();
    seq_tick();
    chk("fault", 32'(FAULT), 32'd1);
    chk("fault_halt", 32'(HALTED), 32'd1);
    chk("fault_hold", 32'(I), 32'd14);
    RESUME = 1'b1;
    seq_tick();
    RESUME = 1'b0;
    chk("refault", 32'({FAULT, HALTED}), 32'd3);

    // halt bit on the jump word suppresses the faulting fetch
    do_reset();
    wr(0, mk(2, 1, 1, 0, 0, 0, 12'h040, 1));
    start_pulse();
    seq_tick();
    chk("halt_prec", 32'({FAULT, HALTED}), 32'd1);

    // random phase
    do_reset();
    for (int k = 0; k < 64; k++) begin
      w = 24'($urandom) & 24'h7FFFFF;
      if ($urandom_range(0, 3) == 0) w[23] = 1'b1;
      wr(k, w);
    end
    wif.WE_VALID = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      if ($urandom_range(0, 29) == 0) Y = 12'($urandom);
      else Y = 12'($urandom_range(0, 63));
      STATUS = 8'($urandom);
      START = ($urandom_range(0, 5) == 0);
      STEP = ($urandom_range(0, 2) == 0);
      RESUME = ($urandom_range(0, 3) == 0);
      wif.WE_VALID = ($urandom_range(0, 1) == 0);
      wif.WE_ADDR = 6'($urandom);
      wif.WE_DATA = 24'($urandom);
      tick();
    end
    START = 1'b0;
    STEP = 1'b0;
    RESUME = 1'b0;
    wif.WE_VALID = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
